// File: rtl/win_pkg.sv
// Shared definitions for the 3x3 window generator: default geometry,
// pixel and coordinate types, and a wrap-around increment helper.
package win_pkg;

    localparam int DW_DEF    = 8;
    localparam int IMG_W_DEF = 256;
    localparam int IMG_H_DEF = 256;
    localparam int CW        = 12;

    typedef logic [DW_DEF-1:0] pix_t;
    typedef logic [CW-1:0]     coord_t;

    // Next coordinate with wrap to zero after the last index
    function automatic coord_t wrap_inc(input coord_t value, input coord_t last);
        return (value == last) ? '0 : coord_t'(value + coord_t'(1));
    endfunction

endpackage

// File: rtl/win3x3_gen_if.sv
// Pixel-stream-in / window-out bundle of the 3x3 window generator.
// The slave modport is the generator side, the master modport the source/sink side.
interface win3x3_gen_if #(
    parameter int DW = win_pkg::DW_DEF
);
    import win_pkg::*;

    logic          pix_valid;
    logic [DW-1:0] pix_in;
    logic          sof;
    logic          win_valid;
    logic [DW-1:0] din0;
    logic [DW-1:0] din1;
    logic [DW-1:0] din2;
    logic [DW-1:0] din3;
    logic [DW-1:0] din4;
    logic [DW-1:0] din5;
    logic [DW-1:0] din6;
    logic [DW-1:0] din7;
    logic [DW-1:0] din8;
    coord_t        win_row;
    coord_t        win_col;

    modport master (
        output pix_valid, pix_in, sof,
        input  win_valid, din0, din1, din2, din3, din4, din5, din6, din7, din8,
               win_row, win_col
    );

    modport slave (
        input  pix_valid, pix_in, sof,
        output win_valid, din0, din1, din2, din3, din4, din5, din6, din7, din8,
               win_row, win_col
    );

endinterface

// File: rtl/win3x3_gen_line_buf.sv
// One-line delay: the output is the value written DEPTH writes earlier.
// The read happens at the write pointer before it is overwritten, so the
// delay is counted in accepted pixels, not in clock cycles.
module line_buf #(
    parameter int DEPTH = 256,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] ptr;

    assign dout = mem[ptr];

    // Storage write; contents are don't-care until a full line has passed
    always_ff @(posedge clk) begin
        if (we) begin
            mem[ptr] <= din;
        end
    end

    // Circular write/read pointer, advancing once per accepted pixel
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (we) begin
            ptr <= (ptr == AW'(DEPTH - 1)) ? '0 : ptr + AW'(1);
        end
    end

endmodule

// File: rtl/win3x3_gen.sv
// 3x3 sliding-window generator over a raster pixel stream.
// Optional macro WIN3X3_FRAME_CNT_EN adds frame_done / frame_cnt outputs.
module win3x3_gen
    import win_pkg::*;
#(
    parameter int IMG_W = IMG_W_DEF,
    parameter int IMG_H = IMG_H_DEF,
    parameter int DW    = DW_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    win3x3_gen_if.slave bus
`ifdef WIN3X3_FRAME_CNT_EN
    ,
    output logic        frame_done,
    output logic [15:0] frame_cnt
`endif
);
    localparam coord_t LAST_COL = coord_t'(IMG_W - 1);
    localparam coord_t LAST_ROW = coord_t'(IMG_H - 1);

    logic          accept;
    coord_t        row;
    coord_t        col;
    coord_t        cur_row;
    coord_t        cur_col;
    logic          win_hit;
    logic [DW-1:0] line1_out;
    logic [DW-1:0] line2_out;
    logic [DW-1:0] win [9];
    logic          win_valid_q;
    coord_t        win_row_q;
    coord_t        win_col_q;

    assign accept = bus.pix_valid;

    // A start-of-frame pixel is placed at the origin whatever the counters say
    always_comb begin
        cur_row = row;
        cur_col = col;
        if (bus.sof) begin
            cur_row = '0;
            cur_col = '0;
        end
        win_hit = accept && (cur_row >= coord_t'(2)) && (cur_col >= coord_t'(2));
    end

    // Raster position of the next pixel; idle sof re-arms the origin
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row <= '0;
            col <= '0;
        end else if (accept) begin
            col <= wrap_inc(cur_col, LAST_COL);
            row <= (cur_col == LAST_COL) ? wrap_inc(cur_row, LAST_ROW) : cur_row;
        end else if (bus.sof) begin
            row <= '0;
            col <= '0;
        end
    end

    line_buf #(
        .DEPTH (IMG_W),
        .DW    (DW)
    ) u_line1 (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (accept),
        .din   (bus.pix_in),
        .dout  (line1_out)
    );

    line_buf #(
        .DEPTH (IMG_W),
        .DW    (DW)
    ) u_line2 (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (accept),
        .din   (line1_out),
        .dout  (line2_out)
    );

    // Window columns shift left; the right column takes line-2, line-1 and the new pixel
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win <= '{default: '0};
        end else if (accept) begin
            win[0] <= win[1];
            win[1] <= win[2];
            win[2] <= line2_out;
            win[3] <= win[4];
            win[4] <= win[5];
            win[5] <= line1_out;
            win[6] <= win[7];
            win[7] <= win[8];
            win[8] <= bus.pix_in;
        end
    end

    // Flag a complete window and latch its centre coordinates
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_valid_q <= 1'b0;
            win_row_q   <= '0;
            win_col_q   <= '0;
        end else begin
            win_valid_q <= win_hit;
            if (win_hit) begin
                win_row_q <= cur_row - coord_t'(1);
                win_col_q <= cur_col - coord_t'(1);
            end
        end
    end

    assign bus.win_valid = win_valid_q;
    assign bus.win_row   = win_row_q;
    assign bus.win_col   = win_col_q;
    assign bus.din0      = win[0];
    assign bus.din1      = win[1];
    assign bus.din2      = win[2];
    assign bus.din3      = win[3];
    assign bus.din4      = win[4];
    assign bus.din5      = win[5];
    assign bus.din6      = win[6];
    assign bus.din7      = win[7];
    assign bus.din8      = win[8];

`ifdef WIN3X3_FRAME_CNT_EN
    logic last_pix;

    assign last_pix = accept && (cur_row == LAST_ROW) && (cur_col == LAST_COL);

    // One-cycle pulse after the last pixel of a frame, with a wrapping frame count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_done <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            frame_done <= last_pix;
            if (last_pix) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_win3x3_gen.sv
// Directed testbench for win3x3_gen on a 4x4 image with pixel = 10*row + col.
module tb_win3x3_gen;
    import win_pkg::*;

    localparam int W = 4;
    localparam int H = 4;
    localparam int D = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    win3x3_gen_if #(.DW(D)) bus ();

`ifdef WIN3X3_FRAME_CNT_EN
    logic        frame_done;
    logic [15:0] frame_cnt;
`endif

    win3x3_gen #(
        .IMG_W (W),
        .IMG_H (H),
        .DW    (D)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus)
`ifdef WIN3X3_FRAME_CNT_EN
        ,
        .frame_done (frame_done),
        .frame_cnt  (frame_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [D-1:0] get_din(input int k);
        case (k)
            0: return bus.din0;
            1: return bus.din1;
            2: return bus.din2;
            3: return bus.din3;
            4: return bus.din4;
            5: return bus.din5;
            6: return bus.din6;
            7: return bus.din7;
            default: return bus.din8;
        endcase
    endfunction

    // Present one pixel for one clock edge, then leave outputs settled for sampling
    task automatic drive_pixel(input int val, input bit s);
        @(negedge clk);
        bus.pix_valid = 1'b1;
        bus.pix_in    = D'(val);
        bus.sof       = s;
        @(posedge clk);
        #1;
        bus.pix_valid = 1'b0;
        bus.sof       = 1'b0;
    endtask

    task automatic idle_cycle(input bit s);
        @(negedge clk);
        bus.pix_valid = 1'b0;
        bus.sof       = s;
        @(posedge clk);
        #1;
        bus.sof = 1'b0;
    endtask

    task automatic test_reset();
        bus.pix_valid = 1'b0;
        bus.pix_in    = '0;
        bus.sof       = 1'b0;
        rst_n         = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.win_valid !== 1'b0 || bus.win_row !== 12'd0 || bus.win_col !== 12'd0)
            $display("[TB] FAIL reset_ctrl: valid=%b row=%0d col=%0d required 0/0/0",
                     bus.win_valid, bus.win_row, bus.win_col);
        for (int k = 0; k < 9; k++) begin
            checks++;
            if (get_din(k) !== 8'd0) begin
                errors++;
                $display("[TB] FAIL reset_din%0d: got %0d required 0", k, get_din(k));
            end
        end
        if (bus.win_valid !== 1'b0 || bus.win_row !== 12'd0 || bus.win_col !== 12'd0) errors++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_frame();
        int  nwin = 0;
        bit  exp_v;
        int  e;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                drive_pixel(10 * r + c, 1'b0);
                exp_v = (r >= 2) && (c >= 2);
                checks++;
                if (bus.win_valid !== exp_v) begin
                    errors++;
                    $display("[TB] FAIL frame_valid(%0d,%0d): got %b required %b", r, c, bus.win_valid, exp_v);
                end
                if (exp_v) begin
                    nwin++;
                    checks++;
                    if (bus.win_row !== coord_t'(r - 1) || bus.win_col !== coord_t'(c - 1)) begin
                        errors++;
                        $display("[TB] FAIL frame_centre: got (%0d,%0d) required (%0d,%0d)",
                                 bus.win_row, bus.win_col, r - 1, c - 1);
                    end
                    for (int k = 0; k < 9; k++) begin
                        e = 10 * (r - 2 + k / 3) + (c - 2 + k % 3);
                        checks++;
                        if (get_din(k) !== D'(e)) begin
                            errors++;
                            $display("[TB] FAIL frame_din%0d@(%0d,%0d): got %0d required %0d", k, r, c, get_din(k), e);
                        end
                    end
                end
            end
        end
        checks++;
        if (nwin != 4) begin
            errors++;
            $display("[TB] FAIL frame_count: got %0d required 4", nwin);
        end
    endtask

    task automatic test_gapped();
        int            nwin = 0;
        bit            exp_v;
        bit            prev_v = 1'b0;
        int            e;
        logic [D-1:0]  held;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                drive_pixel(10 * r + c, 1'b0);
                exp_v = (r >= 2) && (c >= 2);
                checks++;
                if (bus.win_valid !== exp_v) begin
                    errors++;
                    $display("[TB] FAIL gap_valid(%0d,%0d): got %b required %b", r, c, bus.win_valid, exp_v);
                end
                if (exp_v) begin
                    nwin++;
                    checks++;
                    if (bus.win_row !== coord_t'(r - 1) || bus.win_col !== coord_t'(c - 1)) begin
                        errors++;
                        $display("[TB] FAIL gap_centre: got (%0d,%0d) required (%0d,%0d)",
                                 bus.win_row, bus.win_col, r - 1, c - 1);
                    end
                    for (int k = 0; k < 9; k++) begin
                        e = 10 * (r - 2 + k / 3) + (c - 2 + k % 3);
                        checks++;
                        if (get_din(k) !== D'(e)) begin
                            errors++;
                            $display("[TB] FAIL gap_din%0d@(%0d,%0d): got %0d required %0d", k, r, c, get_din(k), e);
                        end
                    end
                end
                held = bus.din4;
                idle_cycle(1'b0);
                checks++;
                if (bus.win_valid !== 1'b0 || bus.din4 !== held) begin
                    errors++;
                    $display("[TB] FAIL gap_hold: valid=%b din4=%0d required 0/%0d", bus.win_valid, bus.din4, held);
                end
                prev_v = bus.win_valid;
            end
        end
        checks++;
        if (nwin != 4 || prev_v !== 1'b0) begin
            errors++;
            $display("[TB] FAIL gap_count: got %0d required 4", nwin);
        end
    endtask

    task automatic test_sof();
        int first = -1;
        for (int n = 0; n < 6; n++) drive_pixel(10 * (n / W) + n % W, 1'b0);
        for (int n = 0; n < W * H; n++) begin
            drive_pixel(10 * (n / W) + n % W, n == 0);
            if (bus.win_valid === 1'b1 && first < 0) begin
                first = n;
                checks++;
                if (bus.din0 !== 8'd0 || bus.din4 !== 8'd11 || bus.din8 !== 8'd22 ||
                    bus.win_row !== 12'd1 || bus.win_col !== 12'd1) begin
                    errors++;
                    $display("[TB] FAIL sof_window: din0=%0d din4=%0d din8=%0d centre (%0d,%0d) required 0/11/22 (1,1)",
                             bus.din0, bus.din4, bus.din8, bus.win_row, bus.win_col);
                end
            end
        end
        checks++;
        if (first != 10) begin
            errors++;
            $display("[TB] FAIL sof_latency: first window after %0d pixels required 10", first);
        end
    endtask

    task automatic test_sof_idle();
        int first = -1;
        int nwin  = 0;
        for (int n = 0; n < 5; n++) drive_pixel(10 * (n / W) + n % W, 1'b0);
        idle_cycle(1'b1);
        for (int n = 0; n < W * H; n++) begin
            drive_pixel(10 * (n / W) + n % W, 1'b0);
            if (bus.win_valid === 1'b1) begin
                nwin++;
                if (first < 0) begin
                    first = n;
                    checks++;
                    if (bus.din0 !== 8'd0 || bus.din8 !== 8'd22 || bus.win_row !== 12'd1 || bus.win_col !== 12'd1) begin
                        errors++;
                        $display("[TB] FAIL sof_idle_window: din0=%0d din8=%0d centre (%0d,%0d) required 0/22 (1,1)",
                                 bus.din0, bus.din8, bus.win_row, bus.win_col);
                    end
                end
            end
        end
        checks++;
        if (first != 10 || nwin != 4) begin
            errors++;
            $display("[TB] FAIL sof_idle_timing: first=%0d windows=%0d required 10/4", first, nwin);
        end
    endtask

    task automatic test_mid_reset();
        int first = -1;
        int nwin  = 0;
        for (int n = 0; n < 10; n++) drive_pixel(10 * (n / W) + n % W, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.win_valid !== 1'b0 || bus.win_row !== 12'd0 || bus.win_col !== 12'd0) begin
            errors++;
            $display("[TB] FAIL midrst_ctrl: valid=%b row=%0d col=%0d required 0/0/0",
                     bus.win_valid, bus.win_row, bus.win_col);
        end
        for (int k = 0; k < 9; k++) begin
            checks++;
            if (get_din(k) !== 8'd0) begin
                errors++;
                $display("[TB] FAIL midrst_din%0d: got %0d required 0", k, get_din(k));
            end
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < W * H; n++) begin
            drive_pixel(10 * (n / W) + n % W, 1'b0);
            if (bus.win_valid === 1'b1) begin
                nwin++;
                if (first < 0) begin
                    first = n;
                    for (int k = 0; k < 9; k++) begin
                        checks++;
                        if (get_din(k) !== D'(10 * (k / 3) + k % 3)) begin
                            errors++;
                            $display("[TB] FAIL midrst_din%0d: got %0d required %0d", k, get_din(k), 10 * (k / 3) + k % 3);
                        end
                    end
                end
            end
        end
        checks++;
        if (first != 10 || nwin != 4) begin
            errors++;
            $display("[TB] FAIL midrst_timing: first=%0d windows=%0d required 10/4", first, nwin);
        end
    endtask

`ifdef WIN3X3_FRAME_CNT_EN
    task automatic test_frame_cnt();
        bit exp_d;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int f = 0; f < 2; f++) begin
            for (int n = 0; n < W * H; n++) begin
                drive_pixel(10 * (n / W) + n % W, 1'b0);
                exp_d = (n == W * H - 1);
                checks++;
                if (frame_done !== exp_d) begin
                    errors++;
                    $display("[TB] FAIL frame_done(f%0d,n%0d): got %b required %b", f, n, frame_done, exp_d);
                end
            end
            idle_cycle(1'b0);
            checks++;
            if (frame_done !== 1'b0 || frame_cnt !== 16'(f + 1)) begin
                errors++;
                $display("[TB] FAIL frame_cnt: done=%b cnt=%0d required 0/%0d", frame_done, frame_cnt, f + 1);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_frame();
        test_gapped();
        test_sof();
        test_sof_idle();
        test_mid_reset();
`ifdef WIN3X3_FRAME_CNT_EN
        test_frame_cnt();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/win3x3_gen.md
WIN3X3_GEN -- requirements
Module: win3x3_gen

Interface
REQ-001 The block SHALL have parameter IMG_W, default 256, meaning pixels per line (3..4096).
REQ-002 The block SHALL have parameter IMG_H, default 256, meaning lines per frame (3..4096).
REQ-003 The block SHALL have parameter DW, default 8, meaning pixel width in bits.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 pix_valid  input  1  pix_in is accepted on this cycle.
REQ-007 pix_in  input  DW  raster-order pixel, line by line.
REQ-008 sof  input  1  start of frame; qualified as in REQ-016/REQ-017.
REQ-009 win_valid  output  1  din0..din8 hold a complete new window.
REQ-010 din0..din8  output  DW each  3x3 window, row-major: din0 top-left, din4 centre, din8 bottom-right.
REQ-011 win_row, win_col  output  12 each  centre-pixel coordinates of the presented window.

Function
REQ-012 Every accepted pixel SHALL advance col by one; col SHALL wrap IMG_W-1 -> 0 and then advance row; row SHALL wrap IMG_H-1 -> 0 with no stall.
REQ-013 Two line delays SHALL store the previous two lines; window columns SHALL shift left by one per accepted pixel: din6/7/8 <= current line, din3/4/5 <= line-1, din0/1/2 <= line-2 at the same column.
REQ-014 win_valid SHALL assert exactly one cycle after accepting a pixel at (row>=2, col>=2); win_row=row-1, win_col=col-1 of that pixel; latency 1 cycle.
REQ-015 With pix_valid low: no counter, line-buffer or window update; win_valid=0; din*/win_row/win_col hold.
REQ-016 sof with pix_valid high: that pixel SHALL be taken as (0,0), regardless of the current counters.
REQ-017 sof with pix_valid low: counters SHALL clear; the next accepted pixel SHALL be (0,0).
REQ-018 Windows SHALL never straddle a line or frame boundary; columns 0..1 and rows 0..1 yield no win_valid.
REQ-019 Exactly (IMG_W-2)*(IMG_H-2) windows SHALL be produced per uninterrupted frame.

Reset
REQ-020 rst_n low SHALL immediately clear row, col, win_valid, din0..din8, win_row and win_col to 0.
REQ-021 Line-buffer storage needs no reset; after reset release the first accepted pixel SHALL be (0,0).
REQ-022 Reset mid-frame SHALL discard the partial frame; no win_valid until row 2/col 2 of the new count.

Configuration
REQ-023 Macro WIN3X3_FRAME_CNT_EN defined: extra outputs frame_done (1, one-cycle pulse the cycle after accepting pixel (IMG_H-1, IMG_W-1)) and frame_cnt (16, increments on frame_done, wraps, reset 0).
REQ-024 Macro undefined: those ports and their logic SHALL be absent; all other behaviour is identical.

Structure
REQ-025 Package win_pkg SHALL hold the DW default, the IMG_W/IMG_H defaults, the pixel typedef and the coordinate width constant (12).
REQ-026 Sub-module line_buf SHALL implement one IMG_W-deep, DW-wide line delay with a write-enable; it is instantiated twice, cascaded.

Verification
REQ-027 IMG_W=IMG_H=4, pixel=10*row+col, pix_valid continuous -> first win_valid one cycle after pixel 22: din0..din8 = 0,1,2,10,11,12,20,21,22; centre (1,1).
REQ-028 Same frame -> exactly 4 windows, centres (1,1), (1,2), (2,1), (2,2); last one has din0=11, din8=33.
REQ-029 Same frame with pix_valid low every other cycle -> identical window contents and order; win_valid never on two consecutive cycles.
REQ-030 sof with pix_valid asserted on pixel 6 of a frame -> that pixel is treated as (0,0); the next window comes only after 10 further pixels.
REQ-031 rst_n pulsed low after pixel 21 -> all outputs read 0 during reset; a full new frame then yields the REQ-027 window exactly.
REQ-032 WIN3X3_FRAME_CNT_EN defined, two 4x4 frames -> frame_done pulses after each pixel 33; frame_cnt reads 1, then 2.
